// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;
  localparam int UART_DW           = 8;
  localparam int DEF_GAP_CYCLES    = 434;
  localparam int DEF_START_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/uart_tx_arb.sv
// Round-robin share of one UART TX engine between two byte sources; accept-to-start 1 cycle,
// sources see a one-cycle ready only while IDLE and are otherwise held off (busy, gap, timeout).
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [UART_DW-1:0] req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [UART_DW-1:0] req1_data,
  output logic               req1_ready,
  output logic [UART_DW-1:0] tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               grant_id,
  output logic               idle,
  output logic               err_timeout
);

  localparam int CNT_MAX = max_int(GAP_CYCLES, START_TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  state_e             state_q, state_d;
  logic [UART_DW-1:0] tx_data_q, tx_data_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;
  logic               start_q, start_d;
  logic               err_q, err_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pick1, any_req;

  // req1 wins when it is alone or when req0 was served last
  assign pick1   = req1_valid & (~req0_valid | ~last_q);
  assign any_req = req0_valid | req1_valid;

  assign req0_ready  = (state_q == S_IDLE) & req0_valid & ~pick1;
  assign req1_ready  = (state_q == S_IDLE) & pick1;
  assign tx_data     = tx_data_q;
  assign tx_start    = start_q;
  assign grant_id    = grant_q;
  assign idle        = (state_q == S_IDLE);
  assign err_timeout = err_q;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          tx_data_d = pick1 ? req1_data : req0_data;
          grant_d   = pick1;
          last_d    = pick1;
          start_d   = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tx_data_q <= '0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      start_q   <= start_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed table, corner sequences and a randomized reference model.
module tb_uart_tx_arb;
  localparam int GAP_A = 6;
  localparam int TO_A  = 16;
  localparam int GAP_B = 0;
  localparam int TO_B  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;

  logic       a_r0, a_r1, a_start, a_gid, a_idle, a_err, busy_a;
  logic [7:0] a_data;
  logic       b_r0, b_r1, b_start, b_gid, b_idle, b_err, busy_b;
  logic [7:0] b_data;

  uart_tx_arb #(.GAP_CYCLES(GAP_A), .START_TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(a_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(a_r1),
    .tx_data(a_data), .tx_start(a_start), .tx_busy(busy_a),
    .grant_id(a_gid), .idle(a_idle), .err_timeout(a_err));

  uart_tx_arb #(.GAP_CYCLES(GAP_B), .START_TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(b_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(b_r1),
    .tx_data(b_data), .tx_start(b_start), .tx_busy(busy_b),
    .grant_id(b_gid), .idle(b_idle), .err_timeout(b_err));

  // TX engine models: busy for len cycles starting the cycle after tx_start
  int   len_a = 4, len_b = 5;
  logic eng_en_a = 1'b1, eng_en_b = 1'b1;
  int   bc_a, bc_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bc_a <= 0;
    else if (eng_en_a && a_start) bc_a <= len_a;
    else if (bc_a > 0) bc_a <= bc_a - 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bc_b <= 0;
    else if (eng_en_b && b_start) bc_b <= len_b;
    else if (bc_b > 0) bc_b <= bc_b - 1;
  end
  assign busy_a = (bc_a != 0);
  assign busy_b = (bc_b != 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) nx();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_idle_a();
    int i;
    i = 0;
    while (!a_idle && i < 200) begin
      nx(); #1;
      i++;
    end
    chk("wait_idle_a", a_idle, 1'b1);
  endtask

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       er0;
    logic       er1;
    logic [7:0] edat;
    logic       egid;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] sd[3];
    logic       sg[3];
    int         st[3];
    int         ns, t;
    int         free_at, start_at, n, L;
    logic       mlast, pk1, exp_g;
    logic [7:0] exp_d;

    tbl[0] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 8'hA1, 1'b1, 8'hB2, 1'b0, 1'b1, 8'hB2, 1'b1};
    tbl[3] = '{1'b1, 8'hC3, 1'b1, 8'hD4, 1'b1, 1'b0, 8'hC3, 1'b0};
    tbl[4] = '{1'b1, 8'hE5, 1'b0, 8'h00, 1'b1, 1'b0, 8'hE5, 1'b0};
    tbl[5] = '{1'b1, 8'h16, 1'b1, 8'h27, 1'b0, 1'b1, 8'h27, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 8'h38, 1'b0, 1'b1, 8'h38, 1'b1};
    tbl[7] = '{1'b1, 8'h49, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h49, 1'b0};

    req0_data = 8'h00;
    req1_data = 8'h00;
    do_reset();

    // reset values
    chk("rst_idle", a_idle, 1'b1);
    chk("rst_start", a_start, 1'b0);
    chk("rst_data", a_data, 8'h00);
    chk("rst_gid", a_gid, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_r0", a_r0, 1'b0);
    chk("rst_r1", a_r1, 1'b0);
    chk("rst_b_idle", b_idle, 1'b1);

    // table: arbitration order from reset
    len_a = 4;
    for (int k = 0; k < 8; k++) begin
      wait_idle_a();
      req0_valid = tbl[k].v0; req0_data = tbl[k].d0;
      req1_valid = tbl[k].v1; req1_data = tbl[k].d1;
      #1;
      chk($sformatf("tbl%0d_r0", k), a_r0, tbl[k].er0);
      chk($sformatf("tbl%0d_r1", k), a_r1, tbl[k].er1);
      nx();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk($sformatf("tbl%0d_start", k), a_start, tbl[k].er0 | tbl[k].er1);
      if (tbl[k].er0 | tbl[k].er1) begin
        chk($sformatf("tbl%0d_data", k), a_data, tbl[k].edat);
        chk($sformatf("tbl%0d_gid", k), a_gid, tbl[k].egid);
      end else begin
        chk($sformatf("tbl%0d_stay_idle", k), a_idle, 1'b1);
      end
    end

    // both valid from reset, engine busy 10 cycles
    do_reset();
    len_a = 10;
    nx();
    req0_valid = 1'b1; req0_data = 8'hA1;
    req1_valid = 1'b1; req1_data = 8'hB2;
    ns = 0;
    for (int i = 0; i < 3; i++) begin sd[i] = 8'h00; sg[i] = 1'b0; st[i] = 0; end
    for (int i = 0; i < 200 && ns < 3; i++) begin
      nx(); #1;
      if (a_start) begin
        sd[ns] = a_data; sg[ns] = a_gid; st[ns] = cyc;
        ns++;
      end
    end
    chk("rr_nstarts", ns, 3);
    chk("rr_d0", sd[0], 8'hA1);
    chk("rr_d1", sd[1], 8'hB2);
    chk("rr_d2", sd[2], 8'hA1);
    chk("rr_g1", sg[1], 1'b1);
    chk("rr_sp01", ((st[1] - st[0]) >= 10 + GAP_A + 3), 1'b1);
    chk("rr_sp12", ((st[2] - st[1]) >= 10 + GAP_A + 3), 1'b1);

    // zero gap: IDLE one cycle after busy falls, next grant that cycle
    do_reset();
    len_b = 5;
    nx();
    req0_valid = 1'b1; req0_data = 8'h3C;
    #1;
    chk("g0_r0", b_r0, 1'b1);
    nx();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h4D;
    #1;
    chk("g0_start", b_start, 1'b1);
    chk("g0_data", b_data, 8'h3C);
    repeat (5) nx();
    #1;
    chk("g0_busy_last", busy_b, 1'b1);
    nx(); #1;
    chk("g0_fall_busy", busy_b, 1'b0);
    chk("g0_fall_idle", b_idle, 1'b0);
    chk("g0_fall_r1", b_r1, 1'b0);
    nx(); #1;
    chk("g0_idle", b_idle, 1'b1);
    chk("g0_r1", b_r1, 1'b1);
    nx();
    req1_valid = 1'b0;
    #1;

    // start timeout: engine never goes busy
    do_reset();
    eng_en_a = 1'b0;
    nx();
    req0_valid = 1'b1; req0_data = 8'h77;
    #1;
    chk("to_r0", a_r0, 1'b1);
    nx();
    req0_valid = 1'b0;
    #1;
    chk("to_start", a_start, 1'b1);
    repeat (16) nx();
    #1;
    chk("to_err_early", a_err, 1'b0);
    chk("to_idle_early", a_idle, 1'b0);
    nx(); #1;
    chk("to_err", a_err, 1'b1);
    chk("to_idle", a_idle, 1'b1);
    nx(); #1;
    chk("to_err_pulse", a_err, 1'b0);
    eng_en_a = 1'b1;

    // asynchronous reset during WAIT_DONE
    do_reset();
    len_a = 10;
    nx();
    req0_valid = 1'b1; req0_data = 8'h99;
    #1;
    chk("ar_r0", a_r0, 1'b1);
    nx();
    req0_valid = 1'b0;
    #1;
    repeat (3) nx();
    #1;
    chk("ar_busy_state", a_idle, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_idle", a_idle, 1'b1);
    chk("ar_start", a_start, 1'b0);
    chk("ar_data", a_data, 8'h00);
    chk("ar_gid", a_gid, 1'b0);
    chk("ar_err", a_err, 1'b0);
    nx();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    #1;
    chk("ar_first_r0", a_r0, 1'b1);
    chk("ar_first_r1", a_r1, 1'b0);
    nx();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("ar_first_data", a_data, 8'h11);

    // valid raised during GAP is held off until IDLE
    do_reset();
    len_a = 3;
    nx();
    req0_valid = 1'b1; req0_data = 8'h5E;
    #1;
    chk("gp_r0", a_r0, 1'b1);
    nx();
    req0_valid = 1'b0;
    #1;
    repeat (5) nx();
    #1;
    chk("gp_in_gap", a_idle, 1'b0);
    nx();
    req1_valid = 1'b1; req1_data = 8'h6F;
    #1;
    for (int i = 0; i < GAP_A - 1; i++) begin
      chk($sformatf("gp_hold%0d", i), a_r1, 1'b0);
      nx(); #1;
    end
    chk("gp_idle", a_idle, 1'b1);
    chk("gp_r1", a_r1, 1'b1);
    nx();
    req1_valid = 1'b0;
    #1;

    // randomized traffic against a frame-level timing model
    do_reset();
    free_at  = 0;
    start_at = -1;
    mlast    = 1'b1;
    exp_d    = 8'h00;
    exp_g    = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      nx();
      if (a_r0) req0_valid = 1'b0;
      if (a_r1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(2, 0) == 0) begin
        req0_valid = 1'b1; req0_data = 8'($urandom);
      end else if (req0_valid && $urandom_range(15, 0) == 0) begin
        req0_valid = 1'b0;
      end
      if (!req1_valid && $urandom_range(2, 0) == 0) begin
        req1_valid = 1'b1; req1_data = 8'($urandom);
      end else if (req1_valid && $urandom_range(15, 0) == 0) begin
        req1_valid = 1'b0;
      end
      #1;
      n = cyc;
      chk("rnd_idle", a_idle, (n >= free_at));
      if (n >= free_at) begin
        pk1 = req1_valid && (!req0_valid || !mlast);
        chk("rnd_r0", a_r0, req0_valid && !pk1);
        chk("rnd_r1", a_r1, pk1);
        if (req0_valid || req1_valid) begin
          exp_d    = pk1 ? req1_data : req0_data;
          exp_g    = pk1;
          mlast    = pk1;
          L        = $urandom_range(12, 1);
          len_a    = L;
          start_at = n + 1;
          free_at  = n + 3 + L + GAP_A;
        end
      end else begin
        chk("rnd_r0_busy", a_r0, 1'b0);
        chk("rnd_r1_busy", a_r1, 1'b0);
      end
      chk("rnd_start", a_start, (n == start_at));
      if (n == start_at) begin
        chk("rnd_data", a_data, exp_d);
        chk("rnd_gid", a_gid, exp_g);
      end
      chk("rnd_err", a_err, 1'b0);
    end

    t = checks;
    $display("CHECKS %0d ERRORS %0d", t, errors);
    $finish;
  end
endmodule
